bist_ctrl: RTL and testbench
============================

# bist_ctrl

Sequencing controller for the FIFO built-in self-test. On `START` it fills the FIFO from the pattern ROM, then reads the FIFO back while replaying the same ROM addresses. It enables the comparator on each read-back word and accumulates its `PASS` result into a sticky verdict. It sits between the test-mode host interface and the FIFO, the pattern ROM and the comparator.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in words; number of words written and read per test; must be ≥ 2.
- `AW`, `$clog2(DEPTH)`: ROM address width.
- `CW`, `$clog2(DEPTH+1)`: counter / `ERR_COUNT` width.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: sole clock; all state changes on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: level; sampled in `IDLE`/`DONE` to begin a test.
- `FIFO_FULL` in 1: FIFO full flag.
- `FIFO_EMPTY` in 1: FIFO empty flag.
- `PASS` in 1: comparator result, combinational from the current FIFO/ROM outputs.
- `WR_EN` out 1: FIFO write strobe.
- `RD_EN` out 1: FIFO read strobe.
- `ROM_ADDR` out AW: pattern ROM address.
- `COMP_EN` out 1: comparator enable.
- `BUSY` out 1: high in `WRITE`/`READ`.
- `DONE` out 1: high in `DONE`.
- `FAIL` out 1: sticky test verdict.
- `ERR_COUNT` out CW: mismatch count (see Configuration).

## Operation
- The FSM has four states:
  - `IDLE`: all strobes low; `START`=1 → `WRITE`, clearing `FAIL`, `ERR_COUNT` and counters.
  - `WRITE`: issue `ROM_ADDR` 0..DEPTH-1, one per cycle, for DEPTH cycles. `WR_EN` is the address-valid bit registered one cycle later, matching the ROM's 1-cycle read latency. After DEPTH issue cycles plus 1 drain cycle → `READ`.
  - `READ`: `RD_EN`=1 with `ROM_ADDR` 0..DEPTH-1 in the same cycle, for DEPTH cycles. `COMP_EN` is `RD_EN` registered one cycle later. After DEPTH issue cycles plus 1 drain cycle → `DONE`.
  - `DONE`: `DONE`=1; `FAIL`/`ERR_COUNT` held; `START`=1 → `WRITE` (new test, verdict cleared).
- Verdict: in any cycle with `COMP_EN`=1 and `PASS`=0, set `FAIL` at the next edge and increment `ERR_COUNT`.
- Structural failures:
  - `FIFO_FULL`=1 in a cycle with `WR_EN`=1 → `FAIL`=1, drop pending strobes, → `DONE`.
  - `FIFO_EMPTY`=1 in a cycle with `RD_EN`=1 → `FAIL`=1, → `DONE`.
  - Structural failures do not increment `ERR_COUNT`.
- `START` while `BUSY` is ignored.
- `ERR_COUNT` saturates at DEPTH. It cannot exceed DEPTH in a correct run; saturation is defensive.
- `ROM_ADDR` holds 0 outside the issue cycles.

## Timing
- Reset values: state `IDLE`; `WR_EN`, `RD_EN`, `COMP_EN`, `BUSY`, `DONE` and `FAIL` = 0; `ROM_ADDR` = 0; `ERR_COUNT` = 0.
- `RST` mid-test: next cycle is `IDLE` with all outputs at reset values. The FIFO is not flushed; the FIFO's owner resets it.
- Schedule, with `START` sampled at the end of cycle 0:
  - `WRITE` issue cycles: 1..DEPTH.
  - `WR_EN`: cycles 2..DEPTH+1.
  - `READ` issue cycles: DEPTH+2..2·DEPTH+1.
  - `COMP_EN`: cycles DEPTH+3..2·DEPTH+2.
  - `DONE`=1 from cycle 2·DEPTH+3.
- `PASS` is sampled in the same cycle as `COMP_EN`; `FAIL` is visible one cycle later.
- A last-word mismatch is reflected in `FAIL` in the first `DONE` cycle.
- `START` held high in `DONE` restarts a test on every completion (back-to-back mode).

## Configuration
- Macro: `BIST_ERR_COUNT_EN`.
- Defined: mismatch counter implemented; `ERR_COUNT` reports mismatches as above.
- Undefined: no counter register; `ERR_COUNT` tied to 0; `FAIL` behaviour unchanged.

## Structure
- Package `bist_pkg` holds:
  - the state enum `bist_state_t` (`IDLE`, `WRITE`, `READ`, `DONE`);
  - the shared `DEPTH` default;
  - a width helper for AW/CW.
- One sub-module, `bist_cnt`: a loadable up-counter with terminal-count flag. It is used for the issue counter and reused for `ERR_COUNT`.

## Test plan
- Good FIFO, DEPTH=16, `PASS` always 1:
  - 16 `WR_EN` pulses, then 16 `RD_EN` pulses;
  - `DONE`=1 in cycle 35, `FAIL`=0, `ERR_COUNT`=0.
- `PASS` forced 0 on the 3rd and 16th `COMP_EN` cycle → `FAIL`=1 in the first `DONE` cycle, `ERR_COUNT`=2.
- `FIFO_FULL` raised in cycle 8 (during `WR_EN`) → `FAIL`=1, `DONE` next cycle, no `RD_EN` pulses, `ERR_COUNT`=0.
- `FIFO_EMPTY` raised in the 5th `READ` issue cycle → `FAIL`=1, `DONE` next cycle.
- `RST` asserted in the 10th `READ` cycle → all outputs at reset values the next cycle; a subsequent `START` completes a clean run.
- `START` pulsed repeatedly while `BUSY` → ignored. `START` then held high in `DONE` → a new test begins next cycle with `FAIL` cleared.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and sizing helpers for the FIFO BIST sequencer.
package bist_pkg;

    localparam int BIST_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } bist_state_t;

    function automatic int bist_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bist_cnt.sv
// Loadable up-counter with a terminal-count flag at MAX.
module bist_cnt #(
    parameter int W   = 5,
    parameter int MAX = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         tc
);

    assign tc = (q == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (en) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/bist_ctrl.sv
// FIFO BIST sequencer: fill from ROM, read back, compare, sticky verdict.
// Define BIST_ERR_COUNT_EN to build the mismatch counter behind ERR_COUNT.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int DEPTH = BIST_DEPTH,
    parameter int AW    = bist_width(DEPTH),
    parameter int CW    = bist_width(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          FIFO_FULL,
    input  logic          FIFO_EMPTY,
    input  logic          PASS,
    output logic          WR_EN,
    output logic          RD_EN,
    output logic [AW-1:0] ROM_ADDR,
    output logic          COMP_EN,
    output logic          BUSY,
    output logic          DONE,
    output logic          FAIL,
    output logic [CW-1:0] ERR_COUNT
);

    bist_state_t   state;
    bist_state_t   state_nx;
    logic [CW-1:0] cnt;
    logic          cnt_tc;
    logic          cnt_ld;
    logic          issue;
    logic          start_ok;
    logic          full_err;
    logic          empty_err;
    logic          abort;
    logic          mism;
    logic          wr_q;
    logic          comp_q;

    assign start_ok  = START && (state == IDLE || state == bist_pkg::DONE);
    assign issue     = (state == WRITE || state == READ) && !cnt_tc;
    assign full_err  = FIFO_FULL && wr_q;
    assign empty_err = FIFO_EMPTY && RD_EN;
    assign abort     = full_err || empty_err;
    assign mism      = comp_q && !PASS;
    assign cnt_ld    = start_ok || (state == WRITE && cnt_tc);

    // Issue counter runs 0..DEPTH; the DEPTH value marks the drain cycle.
    bist_cnt #(
        .W   (CW),
        .MAX (DEPTH)
    ) u_issue (
        .clk  (CLK),
        .rst  (RST),
        .load (cnt_ld),
        .din  ('0),
        .en   (issue),
        .q    (cnt),
        .tc   (cnt_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (START) state_nx = WRITE;
            end
            WRITE: begin
                if (full_err)    state_nx = bist_pkg::DONE;
                else if (cnt_tc) state_nx = READ;
            end
            READ: begin
                if (empty_err || cnt_tc) state_nx = bist_pkg::DONE;
            end
            bist_pkg::DONE: begin
                if (START) state_nx = WRITE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        BUSY     = (state == WRITE) || (state == READ);
        DONE     = (state == bist_pkg::DONE);
        RD_EN    = (state == READ) && !cnt_tc;
        ROM_ADDR = issue ? cnt[AW-1:0] : '0;
    end

    // Strobes trail the address by one cycle to match ROM/FIFO latency.
    always_ff @(posedge CLK) begin
        if (RST || abort) begin
            wr_q   <= 1'b0;
            comp_q <= 1'b0;
        end else begin
            wr_q   <= (state == WRITE) && !cnt_tc;
            comp_q <= RD_EN;
        end
    end

    assign WR_EN   = wr_q;
    assign COMP_EN = comp_q;

    always_ff @(posedge CLK) begin
        if (RST || start_ok) begin
            FAIL <= 1'b0;
        end else if (mism || abort) begin
            FAIL <= 1'b1;
        end
    end

`ifdef BIST_ERR_COUNT_EN
    logic err_tc;

    bist_cnt #(
        .W   (CW),
        .MAX (DEPTH)
    ) u_err (
        .clk  (CLK),
        .rst  (RST),
        .load (start_ok),
        .din  ('0),
        .en   (mism && !err_tc),
        .q    (ERR_COUNT),
        .tc   (err_tc)
    );
`else
    assign ERR_COUNT = '0;
`endif

endmodule

// File: tb/tb_bist_ctrl.sv
// Scoreboard bench for bist_ctrl: directed runs, expected events queued per cycle.
module tb_bist_ctrl;

    localparam int D = 16;
`ifdef BIST_ERR_COUNT_EN
    localparam bit ERRC = 1'b1;
`else
    localparam bit ERRC = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [5:0] flags;
        logic [3:0] addr;
        logic [4:0] err;
    } rec_t;

    logic       clk = 1'b0;
    logic       RST;
    logic       START;
    logic       FIFO_FULL;
    logic       FIFO_EMPTY;
    logic       PASS;
    logic       WR_EN;
    logic       RD_EN;
    logic [3:0] ROM_ADDR;
    logic       COMP_EN;
    logic       BUSY;
    logic       DONE;
    logic       FAIL;
    logic [4:0] ERR_COUNT;

    rec_t exp_q[$];
    int   cyc;
    int   t0;
    bit   active;
    int   vectors;
    int   miscompares;
    logic rst_s;
    logic done_prev;

    bist_ctrl #(.DEPTH(D)) dut (
        .CLK        (clk),
        .RST        (RST),
        .START      (START),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_EMPTY (FIFO_EMPTY),
        .PASS       (PASS),
        .WR_EN      (WR_EN),
        .RD_EN      (RD_EN),
        .ROM_ADDR   (ROM_ADDR),
        .COMP_EN    (COMP_EN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .FAIL       (FAIL),
        .ERR_COUNT  (ERR_COUNT)
    );

    always #5 clk = ~clk;

    // Monitor: an event is any busy cycle, the first DONE cycle, or a cycle after reset.
    always @(posedge clk) begin
        rec_t       e;
        logic [5:0] f;
        cyc   = cyc + 1;
        rst_s = RST;
        #1;
        f = {BUSY, DONE, WR_EN, RD_EN, COMP_EN, FAIL};
        if (active && (BUSY || (DONE && !done_prev) || rst_s)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected c%0d: got flags=%b addr=%0d err=%0d, required no event",
                         cyc - t0, f, ROM_ADDR, ERR_COUNT);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc - t0 || f !== e.flags || ROM_ADDR !== e.addr
                    || ERR_COUNT !== e.err) begin
                    miscompares++;
                    $display("FAIL c%0d: got cyc=%0d flags=%b addr=%0d err=%0d, required cyc=%0d flags=%b addr=%0d err=%0d",
                             e.cyc, cyc - t0, f, ROM_ADDR, ERR_COUNT,
                             e.cyc, e.flags, e.addr, e.err);
                end
            end
        end
        done_prev = DONE;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    function automatic bit is_mm(input int c, input int a, input int b);
        return (a > 0 && c == D + 2 + a) || (b > 0 && c == D + 2 + b);
    endfunction

    // flags order: busy, done, wr, rd, comp, fail
    task automatic push(input int c, input bit b, input bit dn, input bit w,
                        input bit r, input bit cp, input bit fl,
                        input int a, input int er);
        rec_t x;
        x.cyc   = c;
        x.flags = {b, dn, w, r, cp, fl};
        x.addr  = 4'(a);
        x.err   = ERRC ? 5'(er) : 5'd0;
        exp_q.push_back(x);
    endtask

    task automatic check_drained(input string name);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got %0d events missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called at a negedge; this cycle is cycle 0 of the schedule.
    task automatic run(input string name, input int full_at, input int empty_at,
                       input int mm_a, input int mm_b, input int rst_at,
                       input bit pulse, input bit hold_end);
        int last;
        int er;
        bit fl;
        bit ab;
        fl   = 0;
        ab   = 0;
        er   = 0;
        last = 0;
        for (int c = 1; c <= 2 * D + 3; c++) begin
            bit w;
            bit r;
            bit cp;
            int a;
            if (rst_at > 0 && c == rst_at + 1) begin
                push(c, 0, 0, 0, 0, 0, 0, 0, 0);
                last = c;
                break;
            end
            if (ab || c == 2 * D + 3) begin
                push(c, 0, 1, 0, 0, 0, fl, 0, er);
                last = c;
                break;
            end
            w  = (c >= 2 && c <= D + 1);
            r  = (c >= D + 2 && c <= 2 * D + 1);
            cp = (c >= D + 3 && c <= 2 * D + 2);
            a  = (c <= D) ? c - 1 : (r ? c - D - 2 : 0);
            push(c, 1, 0, w, r, cp, fl, a, er);
            if (cp && is_mm(c, mm_a, mm_b)) begin
                fl = 1;
                if (er < D) er++;
            end
            if ((c == full_at && w) || (c == empty_at && r)) begin
                fl = 1;
                ab = 1;
            end
        end
        START = 1'b1;
        t0    = cyc;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            START      = pulse && (c % 3 == 0);
            FIFO_FULL  = (c == full_at);
            FIFO_EMPTY = (c == empty_at);
            PASS       = !is_mm(c, mm_a, mm_b);
            RST        = (c == rst_at);
            if (c == last) begin
                FIFO_FULL  = 1'b0;
                FIFO_EMPTY = 1'b0;
                PASS       = 1'b1;
                START      = hold_end;
            end
        end
        check_drained(name);
    endtask

    initial begin
        RST         = 1'b0;
        START       = 1'b0;
        FIFO_FULL   = 1'b0;
        FIFO_EMPTY  = 1'b0;
        PASS        = 1'b1;
        active      = 1'b0;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        t0          = 0;
        done_prev   = 1'b0;

        @(negedge clk);
        RST    = 1'b1;
        t0     = cyc;
        active = 1'b1;
        push(1, 0, 0, 0, 0, 0, 0, 0, 0);
        push(2, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        check_drained("reset");
        @(negedge clk);

        run("good", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        run("mismatch", 0, 0, 3, 16, 0, 0, 0);
        @(negedge clk);
        run("full", 8, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        run("empty", 0, D + 6, 0, 0, 0, 0, 0);
        @(negedge clk);
        run("midreset", 0, 0, 0, 0, D + 11, 0, 0);
        @(negedge clk);
        run("after_reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        run("busy_start", 0, 0, 5, 0, 0, 1, 1);
        run("back_to_back", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
